pwm_share_arbiter: RTL and testbench
====================================

# pwm_share_arbiter

Shares one 6-bit PWM pulse engine between several switch-enabled pattern sources. Each source presents an enable switch and a requested duty value; the block arbitrates round-robin and holds each winner for a fixed number of whole PWM periods. Duty and ownership change only at PWM period boundaries, so the shared Pulse output never glitches. It sits between the per-pattern duty sequencers and the board's single Pulse pin.

## Interface
- N_REQ, 4: number of requesters, legal range 2..8.
- CNT_W, 6: PWM counter width; one period is 2^CNT_W sysclk cycles.
- DWELL, 3: whole PWM periods a granted requester keeps the engine before re-arbitration; legal range 1..15.
- sysclk  in  1  single system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset; release is synchronized internally to sysclk.
- Enable_SW  in  N_REQ  per-requester request level from raw switches; asynchronous, 2-flop synchronized inside.
- Duty_Req  in  N_REQ*(CNT_W+1)  packed duty requests; slice i is bits [i*(CNT_W+1) +: CNT_W+1]; sampled only at period boundaries.
- Pulse  out  1  shared PWM output.
- Grant  out  N_REQ  one-hot current owner; all-zero when idle.
- Period_Start  out  1  one-cycle strobe in the first cycle of every PWM period.

## Operation
- PWM counter `count` (CNT_W bits) free-runs 0..2^CNT_W-1 and wraps. Boundary cycle = count all-ones.
- Pulse = (count < duty_act) AND (Grant != 0). duty_act is CNT_W+1 bits. A value of 0 gives constant low; a value of 2^CNT_W gives constant high for the whole period.
- Duty clamp: if the sampled Duty_Req slice exceeds 2^CNT_W, duty_act = 2^CNT_W.
- The state machine has two states, IDLE and SERVE. All transitions are evaluated only in the boundary cycle.
- IDLE: Grant = 0 and Pulse = 0. At a boundary, if any synced request is set, pick a winner round-robin starting at rr_ptr. Load Grant and duty_act from the winner's slice, set dwell = 1, and go to SERVE. With no request, stay in IDLE.
- SERVE, at a boundary, rules are evaluated in this order:
  - a) Owner's synced request is low: go to IDLE, or re-arbitrate immediately if another request is set. The new owner takes effect at the same boundary.
  - b) dwell == DWELL: set rr_ptr = owner+1 (mod N_REQ) and re-arbitrate among all requests from rr_ptr. If the owner is the only requester, it wins again. dwell resets to 1.
  - c) Otherwise: dwell += 1 and duty_act is reloaded from the owner's current slice, so the owner may change duty every period.
- A request dropping mid-period does not cut the current period; the period completes at the old duty.
- Round-robin search covers indices rr_ptr, rr_ptr+1, … with wrap. The first set request wins. rr_ptr is updated only on rule b and on a grant from IDLE (rr_ptr = winner+1).

## Timing
- Reset values: count = 0, Grant = 0, Pulse = 0, Period_Start = 0, state = IDLE, rr_ptr = 0, dwell = 0, duty_act = 0, sync flops = 0.
- Input latency: a switch change reaches the arbiter 2 cycles later via the synchronizer. It acts at the first boundary at or after that point.
- Grant and duty_act are registered at the boundary edge. They are visible from the count = 0 cycle. Pulse is combinational from registered count, duty_act and Grant.
- Period_Start is registered: set at the boundary edge, high during each count = 0 cycle, and 0 during and immediately after reset until the first wrap.
- Minimum ownership is DWELL × 2^CNT_W cycles, unless the owner drops its request.
- Reset asserted mid-period: all outputs go to their reset values asynchronously, with no completion of the period.

## Test plan
- Reset, then Enable_SW = 4'b0001 with duty slice0 = 32: Grant = 0001 from the first count = 0. Pulse is high for 32 of 64 cycles, every period, indefinitely.
- Enable_SW = 4'b0101 with slice0 = 16 and slice2 = 48: ownership alternates 0 → 2 → 0. Each owner holds exactly 3 periods (192 cycles), and the high time matches its duty.
- Owner 1 drops its switch at count = 10 of its 2nd dwell period, with req3 set: that period completes at the old duty, and Grant = 1000 from the next count = 0.
- Slice0 = 64, then 70, then 0: Pulse is constant high for 64 at both 64 and 70 (clamp), and constant low for 0 while Grant stays 0001.
- All switches cleared: the block returns to IDLE at the next boundary with Grant = 0 and Pulse = 0, while Period_Start keeps strobing every 64 cycles.
- Assert rst_n low at count = 20 during SERVE: Pulse and Grant go to 0 immediately. After release, arbitration restarts from rr_ptr = 0.

Source files
------------

// File: rtl/pwm_share_arbiter_if.sv
// Bus bundle between the duty sequencers / board pin and the shared PWM engine.
// The slave side is the arbiter; the master side drives switches and duty requests.
interface pwm_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 6
);
  logic [N_REQ-1:0]           Enable_SW;
  logic [N_REQ*(CNT_W+1)-1:0] Duty_Req;
  logic                       Pulse;
  logic [N_REQ-1:0]           Grant;
  logic                       Period_Start;

  modport master (
    output Enable_SW, Duty_Req,
    input  Pulse, Grant, Period_Start
  );

  modport slave (
    input  Enable_SW, Duty_Req,
    output Pulse, Grant, Period_Start
  );
endinterface

// File: rtl/pwm_share_arbiter.sv
// Round-robin sharing of one PWM pulse engine between N_REQ switch-enabled
// duty sources. Ownership and duty only change in the last cycle of a PWM
// period, so the shared Pulse output never carries a truncated or split pulse.
module pwm_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 6,
  parameter int DWELL = 3
) (
  input  logic               sysclk,
  input  logic               rst_n,
  pwm_share_arbiter_if.slave bus
);
  localparam int DUTY_W = CNT_W + 1;
  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DWL_W  = 4;
  localparam logic [DUTY_W-1:0] DUTY_MAX = {1'b1, {CNT_W{1'b0}}};

  typedef enum logic {S_IDLE, S_SERVE} state_t;

  // Requests above a full period would overflow the compare; pin them at 100 %.
  function automatic logic [DUTY_W-1:0] f_clamp_duty(input logic [DUTY_W-1:0] req);
    return (req > DUTY_MAX) ? DUTY_MAX : req;
  endfunction

  function automatic logic [PTR_W-1:0] f_next_idx(input logic [PTR_W-1:0] idx);
    return (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
  endfunction

  function automatic logic [N_REQ-1:0] f_onehot(input logic [PTR_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  logic              r_rst_meta, r_rst_sync;
  logic              w_rst_n;
  logic [N_REQ-1:0]  r_en_meta, r_en_sync;
  logic [CNT_W-1:0]  r_count;
  logic              r_pstart;
  logic              w_boundary;

  state_t            r_state, w_state_nxt;
  logic [N_REQ-1:0]  r_grant, w_grant_nxt;
  logic [PTR_W-1:0]  r_owner, w_owner_nxt;
  logic [DUTY_W-1:0] r_duty, w_duty_nxt;
  logic [DWL_W-1:0]  r_dwell, w_dwell_nxt;
  logic [PTR_W-1:0]  r_rr_ptr, w_rr_nxt;

  logic [DUTY_W-1:0] w_slice [N_REQ];
  logic              w_owner_req;
  logic              w_rotate;
  logic [PTR_W-1:0]  w_search_ptr;
  logic              w_rr_found;
  logic [PTR_W-1:0]  w_rr_idx;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign w_slice[gi] = bus.Duty_Req[gi*DUTY_W +: DUTY_W];
  end

  // Reset asserts immediately but releases only after two clean sysclk edges.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = r_rst_sync;

  // Two-flop synchronizer for the raw switch levels.
  always_ff @(posedge sysclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_en_meta <= '0;
      r_en_sync <= '0;
    end else begin
      r_en_meta <= bus.Enable_SW;
      r_en_sync <= r_en_meta;
    end
  end

  assign w_boundary = &r_count;

  // Free-running period counter; the strobe marks the count==0 cycle after each wrap.
  always_ff @(posedge sysclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_count  <= '0;
      r_pstart <= 1'b0;
    end else begin
      r_count  <= r_count + 1'b1;
      r_pstart <= w_boundary;
    end
  end

  // On dwell expiry the search starts just past the owner so others get a turn;
  // otherwise it starts at the stored round-robin pointer.
  assign w_owner_req  = r_en_sync[r_owner];
  assign w_rotate     = (r_state == S_SERVE) && w_owner_req && (r_dwell == DWL_W'(DWELL));
  assign w_search_ptr = w_rotate ? f_next_idx(r_owner) : r_rr_ptr;

  // First set request at or after w_search_ptr, with wrap-around.
  always_comb begin
    int j;
    j          = 0;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(w_search_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (r_en_sync[PTR_W'(j)]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = PTR_W'(j);
      end
    end
  end

  // Arbitration decisions, taken only in the boundary cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_duty_nxt  = r_duty;
    w_dwell_nxt = r_dwell;
    w_rr_nxt    = r_rr_ptr;
    if (w_boundary) begin
      case (r_state)
        S_IDLE: begin
          if (w_rr_found) begin
            w_state_nxt = S_SERVE;
            w_owner_nxt = w_rr_idx;
            w_grant_nxt = f_onehot(w_rr_idx);
            w_duty_nxt  = f_clamp_duty(w_slice[w_rr_idx]);
            w_dwell_nxt = DWL_W'(1);
            w_rr_nxt    = f_next_idx(w_rr_idx);
          end
        end
        S_SERVE: begin
          if (!w_owner_req) begin
            // Owner released: hand over at once, or fall back to idle.
            if (w_rr_found) begin
              w_owner_nxt = w_rr_idx;
              w_grant_nxt = f_onehot(w_rr_idx);
              w_duty_nxt  = f_clamp_duty(w_slice[w_rr_idx]);
              w_dwell_nxt = DWL_W'(1);
            end else begin
              w_state_nxt = S_IDLE;
              w_grant_nxt = '0;
              w_duty_nxt  = '0;
              w_dwell_nxt = '0;
            end
          end else if (w_rotate) begin
            // The owner is still requesting, so the search always finds someone.
            w_rr_nxt    = f_next_idx(r_owner);
            w_owner_nxt = w_rr_idx;
            w_grant_nxt = f_onehot(w_rr_idx);
            w_duty_nxt  = f_clamp_duty(w_slice[w_rr_idx]);
            w_dwell_nxt = DWL_W'(1);
          end else begin
            w_dwell_nxt = r_dwell + 1'b1;
            w_duty_nxt  = f_clamp_duty(w_slice[r_owner]);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Arbiter state register.
  always_ff @(posedge sysclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_duty   <= '0;
      r_dwell  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_owner  <= w_owner_nxt;
      r_duty   <= w_duty_nxt;
      r_dwell  <= w_dwell_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  assign bus.Pulse        = ({1'b0, r_count} < r_duty) && (r_grant != '0);
  assign bus.Grant        = r_grant;
  assign bus.Period_Start = r_pstart;

endmodule

// File: tb/tb_pwm_share_arbiter.sv
// Self-checking bench for pwm_share_arbiter: per-period grant / high-time
// expectations are queued as stimulus rows are applied and checked as each
// PWM period completes.
module tb_pwm_share_arbiter;
  localparam int N_REQ = 4;
  localparam int CNT_W = 6;
  localparam int DWELL = 3;
  localparam int PER   = 64;
  localparam int MAXV  = 32;

  typedef struct {
    int          p;
    logic [3:0]  en;
    logic [27:0] duty;
    logic [3:0]  g;
    int          h;
  } vec_t;

  typedef struct {
    int         p;
    logic [3:0] g;
    int         h;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   k     = 0;

  vec_t tbl [MAXV];
  int   nv = 0;
  exp_t q [$];

  int         m_high = 0;
  logic [3:0] m_g0   = '0;
  bit         m_gchg = 1'b0;
  bit         m_ps_ok = 1'b1;
  int         m_c, m_p;

  pwm_share_arbiter_if #(.N_REQ(N_REQ), .CNT_W(CNT_W)) bus ();

  pwm_share_arbiter #(.N_REQ(N_REQ), .CNT_W(CNT_W), .DWELL(DWELL)) dut (
    .sysclk (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the DUT count is 0 after edge 2 and then wraps every 64.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  function automatic int cur_p();
    return (k < 2) ? -1 : (k - 2) / PER;
  endfunction

  function automatic int cur_c();
    return (k < 2) ? 0 : (k - 2) % PER;
  endfunction

  function automatic logic [27:0] pk(input int d0, input int d1, input int d2, input int d3);
    return {7'(d3), 7'(d2), 7'(d1), 7'(d0)};
  endfunction

  task automatic chk(input string nm, input int p, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s p=%0d got=%0d want=%0d", nm, p, act, exp);
    end
  endtask

  task automatic add(input int p, input logic [3:0] en, input logic [27:0] d,
                     input logic [3:0] g, input int h);
    tbl[nv] = '{p, en, d, g, h};
    nv++;
  endtask

  task automatic wait_pc(input int p, input int c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(cur_p() == p && cur_c() == c) && n < 20000);
    if (n >= 20000) begin
      total++;
      bad++;
      $display("FAIL wait_timeout p=%0d c=%0d", p, c);
    end
  endtask

  task automatic check_period(input int p);
    exp_t e;
    while (q.size() > 0 && q[0].p < p) begin
      e = q.pop_front();
      total++;
      bad++;
      $display("FAIL missed_period p=%0d got=none want=checked", e.p);
    end
    if (q.size() > 0 && q[0].p == p) begin
      e = q.pop_front();
      chk("grant", p, int'(m_g0), int'(e.g));
      chk("high_time", p, m_high, e.h);
      chk("grant_stable", p, int'(m_gchg), 0);
      chk("period_start", p, int'(m_ps_ok), 1);
    end
  endtask

  // Per-period monitor: high time, grant stability and strobe placement.
  always @(negedge clk) begin
    if (rst_n && k >= 2) begin
      m_c = cur_c();
      m_p = cur_p();
      if (m_c == 0) begin
        m_high  = 0;
        m_g0    = bus.Grant;
        m_gchg  = 1'b0;
        m_ps_ok = (bus.Period_Start === (m_p >= 1));
      end else begin
        if (bus.Grant !== m_g0) m_gchg = 1'b1;
        if (bus.Period_Start !== 1'b0) m_ps_ok = 1'b0;
      end
      if (bus.Pulse === 1'b1) m_high = m_high + 1;
      if (m_c == PER - 1) check_period(m_p);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Enable_SW = '0;
    bus.Duty_Req  = '0;

    // Row p: inputs applied at count 10 of period p-1, expectation for period p.
    add( 1, 4'b0001, pk(32, 0, 0, 0),   4'b0001, 32);
    add( 2, 4'b0001, pk(32, 0, 0, 0),   4'b0001, 32);
    add( 3, 4'b0001, pk(32, 0, 0, 0),   4'b0001, 32);
    add( 4, 4'b0001, pk(32, 0, 0, 0),   4'b0001, 32);
    add( 5, 4'b0001, pk(64, 0, 0, 0),   4'b0001, 64);
    add( 6, 4'b0001, pk(70, 0, 0, 0),   4'b0001, 64);
    add( 7, 4'b0001, pk(0, 0, 0, 0),    4'b0001, 0);
    add( 8, 4'b0001, pk(127, 0, 0, 0),  4'b0001, 64);
    add( 9, 4'b0101, pk(16, 0, 48, 0),  4'b0001, 16);
    add(10, 4'b0101, pk(16, 0, 48, 0),  4'b0100, 48);
    add(11, 4'b0101, pk(16, 0, 48, 0),  4'b0100, 48);
    add(12, 4'b0101, pk(16, 0, 48, 0),  4'b0100, 48);
    add(13, 4'b0101, pk(16, 0, 48, 0),  4'b0001, 16);
    add(14, 4'b0101, pk(16, 0, 48, 0),  4'b0001, 16);
    add(15, 4'b0101, pk(16, 0, 48, 0),  4'b0001, 16);
    add(16, 4'b0101, pk(16, 0, 48, 0),  4'b0100, 48);
    add(17, 4'b1010, pk(16, 24, 48, 40), 4'b0010, 24);
    add(18, 4'b1010, pk(16, 24, 48, 40), 4'b0010, 24);
    add(19, 4'b1000, pk(16, 24, 48, 40), 4'b1000, 40);
    add(20, 4'b1000, pk(16, 24, 48, 40), 4'b1000, 40);
    add(21, 4'b0000, pk(16, 24, 48, 40), 4'b0000, 0);
    add(22, 4'b0000, pk(16, 24, 48, 40), 4'b0000, 0);
    add(23, 4'b0101, pk(16, 24, 48, 40), 4'b0100, 48);
    add(24, 4'b0101, pk(16, 24, 48, 40), 4'b0100, 48);
    add(25, 4'b0101, pk(16, 24, 48, 40), 4'b0100, 48);
    add(26, 4'b0101, pk(16, 24, 48, 40), 4'b0001, 16);

    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_grant",  -1, int'(bus.Grant), 0);
    chk("reset_pulse",  -1, int'(bus.Pulse), 0);
    chk("reset_pstart", -1, int'(bus.Period_Start), 0);
    rst_n = 1'b1;
    q.push_back('{0, 4'b0000, 0});

    for (int i = 0; i < nv; i++) begin
      wait_pc(tbl[i].p - 1, 10);
      bus.Enable_SW = tbl[i].en;
      bus.Duty_Req  = tbl[i].duty;
      q.push_back('{tbl[i].p, tbl[i].g, tbl[i].h});
    end

    // Reset in the middle of a served period with Pulse high.
    wait_pc(26, 10);
    bus.Duty_Req = pk(40, 24, 48, 40);
    wait_pc(27, 20);
    chk("pre_reset_pulse", 27, int'(bus.Pulse), 1);
    chk("pre_reset_grant", 27, int'(bus.Grant), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_pulse",  27, int'(bus.Pulse), 0);
    chk("async_reset_grant",  27, int'(bus.Grant), 0);
    chk("async_reset_pstart", 27, int'(bus.Period_Start), 0);
    bus.Enable_SW = 4'b1100;
    repeat (3) @(negedge clk);
    chk("held_reset_grant", -1, int'(bus.Grant), 0);
    rst_n = 1'b1;
    // Pointer back at 0 picks requester 2 first, then 3 after the dwell.
    q.push_back('{0, 4'b0000, 0});
    q.push_back('{1, 4'b0100, 48});
    q.push_back('{4, 4'b1000, 40});
    wait_pc(5, 1);
    chk("queue_drained", -1, q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
